rpsc_hv_sequencer: RTL and testbench



---
 rtl/rpsc_hv_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_rpsc_hv_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rpsc_hv_sequencer.sv
// rtl/rpsc_hv_sequencer.sv - G1/anode HV power sequencer with timeouts and latched first-fault
module rpsc_hv_sequencer #(
   parameter int G1_TIMEOUT = 160,
   parameter int AN_TIMEOUT = 320,
   parameter int OFF_DELAY  = 64,
   parameter int CNT_W      = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_req,
   input  logic       stop_req,
   input  logic       fault_ack,
   input  logic       not_alarm_g1,
   input  logic       not_alarm_an,
   input  logic       not_g1_ok,
   input  logic       not_th_an_ready,
   input  logic       not_an_ok,
   output logic       g1_ps_act,
   output logic       an_ps_act,
   output logic [2:0] state_o,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       hv_ready
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_G1_RAMP  = 3'd1;
   localparam logic [2:0] S_AN_WAIT  = 3'd2;
   localparam logic [2:0] S_AN_RAMP  = 3'd3;
   localparam logic [2:0] S_RUN      = 3'd4;
   localparam logic [2:0] S_SHUTDOWN = 3'd5;
   localparam logic [2:0] S_FAULT    = 3'd6;

   localparam logic [CNT_W-1:0] G1_LAST  = CNT_W'(G1_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] AN_LAST  = CNT_W'(AN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_DELAY - 1);

   logic [2:0]       state;
   logic [2:0]       next_state;
   logic [2:0]       next_code;
   logic [2:0]       alarm_code;
   logic [CNT_W-1:0] timer;
   logic             clr_timer;
   logic             counting;
   logic             armed;
   logic             alarms_clear;
   logic             fault_exit;

   assign alarms_clear = not_alarm_g1 & not_alarm_an;
   assign fault_exit   = (state == S_FAULT) && fault_ack && alarms_clear;
   assign counting     = (state == S_G1_RAMP) || (state == S_AN_WAIT) ||
                         (state == S_AN_RAMP) || (state == S_SHUTDOWN);
   assign state_o      = state;

   // G1 alarm wins when both alarms land in the same cycle
   always_comb begin
      alarm_code = 3'd0;
      if (!not_alarm_g1)
         alarm_code = 3'd6;
      else if (!not_alarm_an)
         alarm_code = 3'd7;
   end

   always_comb begin
      next_state = state;
      next_code  = 3'd0;
      clr_timer  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_req && alarms_clear && !stop_req && armed) begin
               next_state = S_G1_RAMP;
               clr_timer  = 1'b1;
            end
         end
         S_G1_RAMP: begin
            // anode alarm is not meaningful before the anode supply is enabled
            if (!not_alarm_g1) begin
               next_state = S_FAULT;
               next_code  = 3'd6;
            end else if (not_g1_ok && timer == G1_LAST) begin
               next_state = S_FAULT;
               next_code  = 3'd1;
            end else if (stop_req) begin
               next_state = S_IDLE;
            end else if (!not_g1_ok) begin
               next_state = S_AN_WAIT;
               clr_timer  = 1'b1;
            end
         end
         S_AN_WAIT: begin
            if (alarm_code != 3'd0) begin
               next_state = S_FAULT;
               next_code  = alarm_code;
            end else if (not_th_an_ready && timer == G1_LAST) begin
               next_state = S_FAULT;
               next_code  = 3'd2;
            end else if (stop_req) begin
               next_state = S_IDLE;
            end else if (!not_th_an_ready) begin
               next_state = S_AN_RAMP;
               clr_timer  = 1'b1;
            end
         end
         S_AN_RAMP: begin
            if (alarm_code != 3'd0) begin
               next_state = S_FAULT;
               next_code  = alarm_code;
            end else if (not_an_ok && timer == AN_LAST) begin
               next_state = S_FAULT;
               next_code  = 3'd3;
            end else if (stop_req) begin
               next_state = S_SHUTDOWN;
               clr_timer  = 1'b1;
            end else if (!not_an_ok) begin
               next_state = S_RUN;
            end
         end
         S_RUN: begin
            if (alarm_code != 3'd0) begin
               next_state = S_FAULT;
               next_code  = alarm_code;
            end else if (not_g1_ok) begin
               next_state = S_FAULT;
               next_code  = 3'd4;
            end else if (not_an_ok) begin
               next_state = S_FAULT;
               next_code  = 3'd5;
            end else if (stop_req) begin
               next_state = S_SHUTDOWN;
               clr_timer  = 1'b1;
            end
         end
         S_SHUTDOWN: begin
            if (alarm_code != 3'd0) begin
               next_state = S_FAULT;
               next_code  = alarm_code;
            end else if (timer == OFF_LAST) begin
               next_state = S_IDLE;
            end
         end
         S_FAULT: begin
            if (fault_exit)
               next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         timer      <= '0;
         armed      <= 1'b1;
         g1_ps_act  <= 1'b0;
         an_ps_act  <= 1'b0;
         hv_ready   <= 1'b0;
         fault      <= 1'b0;
         fault_code <= 3'd0;
      end else begin
         state <= next_state;
         if (clr_timer)
            timer <= '0;
         else if (counting)
            timer <= timer + 1'b1;
         g1_ps_act <= (next_state == S_G1_RAMP) || (next_state == S_AN_WAIT) ||
                      (next_state == S_AN_RAMP) || (next_state == S_RUN) ||
                      (next_state == S_SHUTDOWN);
         an_ps_act <= (next_state == S_AN_RAMP) || (next_state == S_RUN);
         hv_ready  <= (next_state == S_RUN);
         fault     <= (next_state == S_FAULT);
         // only the entry into FAULT records a cause, so the first one sticks
         if (next_state == S_FAULT && state != S_FAULT)
            fault_code <= next_code;
         else if (fault_exit)
            fault_code <= 3'd0;
         // a start held across a fault clear must drop once before it counts again
         if (fault_exit)
            armed <= ~start_req;
         else if (!start_req)
            armed <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// tb/tb_rpsc_hv_sequencer.sv - randomized and directed bench for rpsc_hv_sequencer against a phase/dwell model
module tb_rpsc_hv_sequencer;

   localparam int G1_TIMEOUT = 160;
   localparam int AN_TIMEOUT = 320;
   localparam int OFF_DELAY  = 64;

   localparam int P_IDLE = 0, P_G1 = 1, P_ANW = 2, P_ANR = 3, P_RUN = 4, P_SD = 5, P_FLT = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_req = 1'b0;
   logic       stop_req = 1'b0;
   logic       fault_ack = 1'b0;
   logic       not_alarm_g1 = 1'b1;
   logic       not_alarm_an = 1'b1;
   logic       not_g1_ok = 1'b1;
   logic       not_th_an_ready = 1'b1;
   logic       not_an_ok = 1'b1;
   logic       g1_ps_act;
   logic       an_ps_act;
   logic [2:0] state_o;
   logic       fault;
   logic [2:0] fault_code;
   logic       hv_ready;

   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   // reference model: phase, the cycle it was entered, first-fault code, start qualifier
   int m_ph = P_IDLE;
   int m_enter = 0;
   int m_code = 0;
   bit m_armed = 1'b1;
   int cyc = 0;

   rpsc_hv_sequencer dut (
      .clk(clk), .reset(reset), .start_req(start_req), .stop_req(stop_req),
      .fault_ack(fault_ack), .not_alarm_g1(not_alarm_g1), .not_alarm_an(not_alarm_an),
      .not_g1_ok(not_g1_ok), .not_th_an_ready(not_th_an_ready), .not_an_ok(not_an_ok),
      .g1_ps_act(g1_ps_act), .an_ps_act(an_ps_act), .state_o(state_o), .fault(fault),
      .fault_code(fault_code), .hv_ready(hv_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [9:0] model_out();
      logic [2:0] ph3;
      logic [2:0] c3;
      ph3 = 3'(m_ph);
      c3  = 3'(m_code);
      return {ph3, 1'(m_ph >= P_G1 && m_ph <= P_SD), 1'(m_ph == P_ANR || m_ph == P_RUN),
              1'(m_ph == P_FLT), c3, 1'(m_ph == P_RUN)};
   endfunction

   function automatic logic [9:0] dut_out();
      return {state_o, g1_ps_act, an_ps_act, fault, fault_code, hv_ready};
   endfunction

   task automatic go(input int ph);
      m_ph = ph;
      m_enter = cyc + 1;
   endtask

   task automatic trip(input int code);
      m_ph = P_FLT;
      m_code = code;
   endtask

   always @(posedge clk) begin
      int  dwell;
      int  alarm;
      bit  exit_flt;
      dwell = cyc - m_enter;
      alarm = !not_alarm_g1 ? 6 : (!not_alarm_an ? 7 : 0);
      exit_flt = (m_ph == P_FLT) && fault_ack && not_alarm_g1 && not_alarm_an;
      if (reset) begin
         m_ph = P_IDLE; m_code = 0; m_armed = 1'b1;
      end else begin
         bit old_armed;
         old_armed = m_armed;
         if (exit_flt) m_armed = !start_req;
         else if (!start_req) m_armed = 1'b1;
         case (m_ph)
            P_IDLE: if (start_req && not_alarm_g1 && not_alarm_an && !stop_req && old_armed) go(P_G1);
            P_G1: begin
               if (!not_alarm_g1) trip(6);
               else if (not_g1_ok && dwell == G1_TIMEOUT - 1) trip(1);
               else if (stop_req) go(P_IDLE);
               else if (!not_g1_ok) go(P_ANW);
            end
            P_ANW: begin
               if (alarm != 0) trip(alarm);
               else if (not_th_an_ready && dwell == G1_TIMEOUT - 1) trip(2);
               else if (stop_req) go(P_IDLE);
               else if (!not_th_an_ready) go(P_ANR);
            end
            P_ANR: begin
               if (alarm != 0) trip(alarm);
               else if (not_an_ok && dwell == AN_TIMEOUT - 1) trip(3);
               else if (stop_req) go(P_SD);
               else if (!not_an_ok) go(P_RUN);
            end
            P_RUN: begin
               if (alarm != 0) trip(alarm);
               else if (not_g1_ok) trip(4);
               else if (not_an_ok) trip(5);
               else if (stop_req) go(P_SD);
            end
            P_SD: begin
               if (alarm != 0) trip(alarm);
               else if (dwell == OFF_DELAY - 1) go(P_IDLE);
            end
            default: if (exit_flt) begin go(P_IDLE); m_code = 0; end
         endcase
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (mon_en) check_eq("cycle", 32'(dut_out()), 32'(model_out()));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // start is already high and state IDLE; G1 OK never arrives
   task automatic g1_timeout_run(input string tag);
      not_g1_ok = 1'b1;
      for (int c = 0; c <= G1_TIMEOUT; c++) begin
         tick();
         if (c + 1 == 1)   check_eq({tag, "_g1_on"}, 32'(g1_ps_act), 32'd1);
         if (c + 1 == 160) check_eq({tag, "_still_ramp"}, 32'(state_o), 32'd1);
         if (c + 1 == 161) begin
            check_eq({tag, "_fault_state"}, 32'(state_o), 32'd6);
            check_eq({tag, "_code"}, 32'(fault_code), 32'd1);
            check_eq({tag, "_enables_off"}, 32'({g1_ps_act, an_ps_act}), 32'd0);
         end
      end
   endtask

   initial begin
      do_reset();
      mon_en = 1'b1;
      check_eq("reset_state", 32'(dut_out()), 32'd0);

      start_req = 1'b1;
      g1_timeout_run("g1to");
      fault_ack = 1'b1; tick(); fault_ack = 1'b0;
      check_eq("g1to_ack_idle", 32'({state_o, fault}), 32'd0);
      repeat (5) tick();
      check_eq("g1to_no_restart", 32'(state_o), 32'd0);
      start_req = 1'b0; tick();
      start_req = 1'b1; tick();
      check_eq("g1to_rearm", 32'(state_o), 32'd1);

      do_reset();
      not_g1_ok = 1'b1; not_th_an_ready = 1'b1; not_an_ok = 1'b1;
      for (int c = 0; c <= 400; c++) begin
         if (c == 130) not_g1_ok = 1'b0;
         if (c == 135) not_th_an_ready = 1'b0;
         if (c == 400) not_an_ok = 1'b0;
         tick();
         if (c + 1 == 1)   check_eq("nom_g1_c1", 32'(g1_ps_act), 32'd1);
         if (c + 1 == 135) check_eq("nom_an_c135", 32'(an_ps_act), 32'd0);
         if (c + 1 == 136) check_eq("nom_an_c136", 32'(an_ps_act), 32'd1);
         if (c + 1 == 400) check_eq("nom_hv_c400", 32'(hv_ready), 32'd0);
         if (c + 1 == 401) check_eq("nom_hv_c401", 32'(hv_ready), 32'd1);
      end

      stop_req = 1'b1; tick(); stop_req = 1'b0;
      check_eq("stop_an_off", 32'({state_o, g1_ps_act, an_ps_act}), {27'd0, 3'd5, 2'b10});
      repeat (OFF_DELAY - 1) tick();
      check_eq("stop_g1_held", 32'(g1_ps_act), 32'd1);
      tick();
      check_eq("stop_g1_off", 32'({state_o, g1_ps_act}), 32'd0);
      start_req = 1'b0; tick();

      start_req = 1'b1;
      repeat (4) tick();
      check_eq("alarm_in_run_pre", 32'(state_o), 32'd4);
      not_alarm_an = 1'b0; tick();
      check_eq("alarm_an_trip", 32'({state_o, g1_ps_act, an_ps_act, fault_code}), {24'd0, 3'd6, 2'b00, 3'd7});
      fault_ack = 1'b1; tick(); fault_ack = 1'b0;
      check_eq("alarm_ack_ignored", 32'(state_o), 32'd6);
      not_alarm_an = 1'b1; tick();
      start_req = 1'b0;
      fault_ack = 1'b1; tick(); fault_ack = 1'b0;
      check_eq("alarm_ack_clear", 32'({state_o, fault, fault_code}), 32'd0);

      not_an_ok = 1'b1;
      start_req = 1'b1;
      repeat (3) tick();
      check_eq("simul_in_anramp", 32'(state_o), 32'd3);
      not_alarm_g1 = 1'b0; not_alarm_an = 1'b0; tick();
      check_eq("simul_code6", 32'(fault_code), 32'd6);
      not_an_ok = 1'b0; tick();
      not_an_ok = 1'b1; tick();
      check_eq("simul_code_sticky", 32'(fault_code), 32'd6);
      not_alarm_g1 = 1'b1; not_alarm_an = 1'b1; start_req = 1'b0;
      fault_ack = 1'b1; tick(); fault_ack = 1'b0;
      check_eq("simul_cleared", 32'(state_o), 32'd0);

      start_req = 1'b1;
      repeat (3) tick();
      check_eq("rst_mid_anramp", 32'(state_o), 32'd3);
      reset = 1'b1; tick(); reset = 1'b0;
      check_eq("rst_mid_outputs", 32'(dut_out()), 32'd0);
      g1_timeout_run("rst_retime");

      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(0, 99) < 3) not_g1_ok = ~not_g1_ok;
         if ($urandom_range(0, 99) < 3) not_th_an_ready = ~not_th_an_ready;
         if ($urandom_range(0, 99) < 2) not_an_ok = ~not_an_ok;
         if (not_alarm_g1) not_alarm_g1 = ($urandom_range(0, 999) >= 3);
         else              not_alarm_g1 = ($urandom_range(0, 9) == 0);
         if (not_alarm_an) not_alarm_an = ($urandom_range(0, 999) >= 3);
         else              not_alarm_an = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 99) == 0) start_req = ~start_req;
         stop_req  = ($urandom_range(0, 299) == 0);
         fault_ack = ($urandom_range(0, 19) == 0);
         reset     = ($urandom_range(0, 2999) == 0);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
